// File: rtl/cpu_io_pkg.sv
// Shared types and constants for the cpu_io_host responder.
package cpu_io_pkg;

  localparam int DATA_W = 8;
  localparam logic [DATA_W-1:0] OUT_COUNT_MAX = 8'd255;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_PULSE  = 3'd2,
    ST_ACK    = 3'd3,
    ST_HALTED = 3'd4
  } state_e;

endpackage

// File: rtl/cpu_io_fifo.sv
// Power-of-two circular FIFO with occupancy count; pushes while full and pops while empty are ignored.
module cpu_io_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0]   CNT_ONE = (PW + 1)'(1);
  localparam logic [PW:0]   CNT_MAX = (PW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             wr_ok, rd_ok;

  assign full_o  = (count_q == CNT_MAX);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign wr_ok = push_i & ~full_o;
  assign rd_ok = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible after being written.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/cpu_io_host.sv
// Host-side I/O responder: feeds Nin/enter from a byte queue and captures CPU OUT values.
// Define CPU_IO_OUTLOG_EN to buffer captured outputs in a DEPTH-entry FIFO instead of one register.
//
// state     | meaning
// ST_IDLE   | waiting for cpu_in_req with a queued byte
// ST_SETUP  | Nin driven, enter low for SETUP cycles
// ST_PULSE  | enter high for ENTER_HOLD cycles
// ST_ACK    | waiting for cpu_in_req to drop
// ST_HALTED | CPU halted, absorbing until reset
module cpu_io_host
  import cpu_io_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int ENTER_HOLD = 4,
  parameter int SETUP      = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [DATA_W-1:0]      host_data,
  input  logic                   host_push,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   fifo_full,
  output logic                   overflow,
  input  logic                   cpu_in_req,
  output logic [DATA_W-1:0]      Nin,
  output logic                   enter,
  output logic                   starved,
  input  logic                   cpu_out_strobe,
  input  logic [DATA_W-1:0]      cpu_Nout,
  input  logic                   cpu_halt,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_valid,
  input  logic                   out_pop,
  output logic [DATA_W-1:0]      out_count,
  output logic                   done
);

  localparam int TMAX  = (SETUP > ENTER_HOLD) ? SETUP : ENTER_HOLD;
  localparam int TMR_W = (TMAX > 2) ? $clog2(TMAX) : 1;
  localparam logic [TMR_W-1:0] SETUP_LAST = TMR_W'((SETUP > 0) ? SETUP - 1 : 0);
  localparam logic [TMR_W-1:0] HOLD_LAST  = TMR_W'(ENTER_HOLD - 1);
  localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);

  state_e            state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [DATA_W-1:0] nin_q, nin_d;
  logic              overflow_q, overflow_d;
  logic [DATA_W-1:0] out_count_q, out_count_d;
  logic              done_q, done_d;

  logic              in_pop;
  logic [DATA_W-1:0] in_rdata;
  logic              in_full, in_empty;

  cpu_io_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W)
  ) u_in_fifo (
    .clk     (clock),
    .rst_n   (reset),
    .push_i  (host_push),
    .wdata_i (host_data),
    .pop_i   (in_pop),
    .rdata_o (in_rdata),
    .count_o (fifo_count),
    .full_o  (in_full),
    .empty_o (in_empty)
  );

  assign fifo_full = in_full;
  assign Nin       = nin_q;
  assign enter     = (state_q == ST_PULSE);
  assign starved   = (state_q == ST_IDLE) & cpu_in_req & in_empty;
  assign overflow  = overflow_q;
  assign out_count = out_count_q;
  assign done      = done_q;

  // Halt overrides every transition, including a pop that would otherwise start a handshake.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    nin_d   = nin_q;
    in_pop  = 1'b0;
    if (cpu_halt) begin
      state_d = ST_HALTED;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cpu_in_req && !in_empty) begin
            in_pop = 1'b1;
            nin_d  = in_rdata;
            if (SETUP == 0) begin
              state_d = ST_PULSE;
              tmr_d   = HOLD_LAST;
            end else begin
              state_d = ST_SETUP;
              tmr_d   = SETUP_LAST;
            end
          end
        end
        ST_SETUP: begin
          if (tmr_q == '0) begin
            state_d = ST_PULSE;
            tmr_d   = HOLD_LAST;
          end else begin
            tmr_d = tmr_q - TMR_ONE;
          end
        end
        ST_PULSE: begin
          if (tmr_q == '0) state_d = ST_ACK;
          else             tmr_d   = tmr_q - TMR_ONE;
        end
        ST_ACK: begin
          if (!cpu_in_req) state_d = ST_IDLE;
        end
        ST_HALTED: state_d = ST_HALTED;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

`ifdef CPU_IO_OUTLOG_EN
  logic              log_full, log_empty;
  logic [DATA_W-1:0] log_rdata;
  logic [$clog2(DEPTH):0] log_count;

  cpu_io_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W)
  ) u_out_fifo (
    .clk     (clock),
    .rst_n   (reset),
    .push_i  (cpu_out_strobe),
    .wdata_i (cpu_Nout),
    .pop_i   (out_pop),
    .rdata_o (log_rdata),
    .count_o (log_count),
    .full_o  (log_full),
    .empty_o (log_empty)
  );

  assign out_valid  = (log_count != '0);
  assign out_data   = log_empty ? '0 : log_rdata;
  assign overflow_d = overflow_q | (host_push & in_full) | (cpu_out_strobe & log_full);
`else
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;

  // A fresh strobe wins over a simultaneous pop so the new byte is never lost.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (cpu_out_strobe) begin
      out_data_d  = cpu_Nout;
      out_valid_d = 1'b1;
    end else if (out_pop) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign overflow_d = overflow_q | (host_push & in_full);
`endif

  always_comb begin
    out_count_d = out_count_q;
    if (cpu_out_strobe && (out_count_q != OUT_COUNT_MAX)) out_count_d = out_count_q + 8'd1;
    done_d = done_q | cpu_halt;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      tmr_q       <= '0;
      nin_q       <= '0;
      overflow_q  <= 1'b0;
      out_count_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      nin_q       <= nin_d;
      overflow_q  <= overflow_d;
      out_count_q <= out_count_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_cpu_io_host.sv
// Directed bench for cpu_io_host with default parameters (DEPTH 8, ENTER_HOLD 4, SETUP 1).
module tb_cpu_io_host;

  logic       clock;
  logic       reset;
  logic [7:0] host_data;
  logic       host_push;
  logic [3:0] fifo_count;
  logic       fifo_full;
  logic       overflow;
  logic       cpu_in_req;
  logic [7:0] Nin;
  logic       enter;
  logic       starved;
  logic       cpu_out_strobe;
  logic [7:0] cpu_Nout;
  logic       cpu_halt;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_pop;
  logic [7:0] out_count;
  logic       done;

  int n_pass  = 0;
  int n_total = 0;

  cpu_io_host dut (
    .clock          (clock),
    .reset          (reset),
    .host_data      (host_data),
    .host_push      (host_push),
    .fifo_count     (fifo_count),
    .fifo_full      (fifo_full),
    .overflow       (overflow),
    .cpu_in_req     (cpu_in_req),
    .Nin            (Nin),
    .enter          (enter),
    .starved        (starved),
    .cpu_out_strobe (cpu_out_strobe),
    .cpu_Nout       (cpu_Nout),
    .cpu_halt       (cpu_halt),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_pop        (out_pop),
    .out_count      (out_count),
    .done           (done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    host_data = b;
    host_push = 1'b1;
    tick();
    host_push = 1'b0;
  endtask

  // Runs one full request; reports delivered byte, enter-high cycles, rising edges and setup delay.
  task automatic handshake(output logic [7:0] got, output int highs, output int rises,
                           output int first);
    logic prev;
    cpu_in_req = 1'b1;
    tick();
    got   = Nin;
    highs = 0;
    rises = 0;
    first = -1;
    prev  = enter;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (enter) highs++;
      if (enter && !prev) rises++;
      if (enter && first < 0) first = i + 1;
      prev = enter;
    end
    cpu_in_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    host_data = 8'h00; host_push = 1'b0; cpu_in_req = 1'b0;
    cpu_out_strobe = 1'b0; cpu_Nout = 8'h00; cpu_halt = 1'b0; out_pop = 1'b0;
    tick();
    tick();
    n_total++;
    if ({Nin, enter, fifo_count, fifo_full, overflow, starved} !== 16'h0)
      $display("FAIL reset_in: got Nin=%h enter=%b cnt=%0d full=%b ovf=%b starved=%b, expected all 0",
               Nin, enter, fifo_count, fifo_full, overflow, starved);
    else n_pass++;
    n_total++;
    if ({out_data, out_valid, out_count, done} !== 18'h0)
      $display("FAIL reset_out: got out_data=%h valid=%b count=%0d done=%b, expected all 0",
               out_data, out_valid, out_count, done);
    else n_pass++;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic_handshake();
    logic [7:0] got;
    int highs, rises, first;
    push_byte(8'h2A);
    n_total++;
    if (fifo_count !== 4'd1) $display("FAIL basic_count: got %0d expected 1", fifo_count);
    else n_pass++;
    handshake(got, highs, rises, first);
    n_total++;
    if (got !== 8'h2A) $display("FAIL basic_nin: got %h expected 2a", got);
    else n_pass++;
    n_total++;
    if (first !== 1) $display("FAIL basic_setup: enter rose after %0d cycles, expected 1", first);
    else n_pass++;
    n_total++;
    if (highs !== 4) $display("FAIL basic_hold: enter high %0d cycles, expected 4", highs);
    else n_pass++;
    n_total++;
    if (rises !== 1) $display("FAIL basic_single: %0d enter pulses, expected 1", rises);
    else n_pass++;
  endtask

  task automatic test_starvation();
    int highs;
    cpu_in_req = 1'b1;
    tick();
    n_total++;
    if (starved !== 1'b1 || enter !== 1'b0)
      $display("FAIL starve_flag: got starved=%b enter=%b, expected 1/0", starved, enter);
    else n_pass++;
    push_byte(8'h05);
    n_total++;
    if (starved !== 1'b0) $display("FAIL starve_clear: got %b expected 0", starved);
    else n_pass++;
    tick();
    n_total++;
    if (Nin !== 8'h05) $display("FAIL starve_nin: got %h expected 05", Nin);
    else n_pass++;
    highs = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (enter) highs++;
    end
    n_total++;
    if (highs !== 4) $display("FAIL starve_pulse: enter high %0d cycles, expected 4", highs);
    else n_pass++;
    cpu_in_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_overflow();
    logic [7:0] got;
    int highs, rises, first;
    for (int i = 1; i <= 9; i++) push_byte(8'(i));
    n_total++;
    if (fifo_count !== 4'd8 || fifo_full !== 1'b1 || overflow !== 1'b1)
      $display("FAIL ovf_flags: got cnt=%0d full=%b ovf=%b, expected 8/1/1",
               fifo_count, fifo_full, overflow);
    else n_pass++;
    for (int i = 1; i <= 4; i++) begin
      handshake(got, highs, rises, first);
      n_total++;
      if (got !== 8'(i) || highs !== 4)
        $display("FAIL ovf_order%0d: got byte %h highs %0d, expected %h / 4", i, got, highs, 8'(i));
      else n_pass++;
    end
    n_total++;
    if (fifo_count !== 4'd4 || fifo_full !== 1'b0)
      $display("FAIL ovf_drain: got cnt=%0d full=%b, expected 4/0", fifo_count, fifo_full);
    else n_pass++;
  endtask

  task automatic test_output_capture();
    cpu_out_strobe = 1'b1;
    cpu_Nout = 8'h11;
    tick();
    cpu_Nout = 8'h22;
    tick();
    cpu_out_strobe = 1'b0;
    n_total++;
    if (out_count !== 8'd2) $display("FAIL out_count: got %0d expected 2", out_count);
    else n_pass++;
`ifdef CPU_IO_OUTLOG_EN
    n_total++;
    if (out_data !== 8'h11 || out_valid !== 1'b1)
      $display("FAIL out_head1: got %h valid %b, expected 11/1", out_data, out_valid);
    else n_pass++;
    out_pop = 1'b1;
    tick();
    out_pop = 1'b0;
    n_total++;
    if (out_data !== 8'h22 || out_valid !== 1'b1)
      $display("FAIL out_head2: got %h valid %b, expected 22/1", out_data, out_valid);
    else n_pass++;
`else
    n_total++;
    if (out_data !== 8'h22 || out_valid !== 1'b1)
      $display("FAIL out_overwrite: got %h valid %b, expected 22/1", out_data, out_valid);
    else n_pass++;
`endif
    out_pop = 1'b1;
    tick();
    out_pop = 1'b0;
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL out_pop: valid got %b expected 0", out_valid);
    else n_pass++;
    cpu_out_strobe = 1'b1;
    cpu_Nout = 8'h5A;
    for (int i = 0; i < 260; i++) tick();
    cpu_out_strobe = 1'b0;
    tick();
    n_total++;
    if (out_count !== 8'd255) $display("FAIL out_saturate: got %0d expected 255", out_count);
    else n_pass++;
  endtask

  task automatic test_halt();
    int seen;
    cpu_in_req = 1'b1;
    tick();
    tick();
    n_total++;
    if (enter !== 1'b1 || Nin !== 8'h05)
      $display("FAIL halt_pre: got enter=%b Nin=%h, expected 1/05", enter, Nin);
    else n_pass++;
    cpu_halt = 1'b1;
    tick();
    cpu_halt = 1'b0;
    n_total++;
    if (enter !== 1'b0 || done !== 1'b1)
      $display("FAIL halt_stop: got enter=%b done=%b, expected 0/1", enter, done);
    else n_pass++;
    cpu_in_req = 1'b0;
    tick();
    cpu_in_req = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (enter) seen++;
    end
    cpu_in_req = 1'b0;
    n_total++;
    if (seen !== 0 || fifo_count !== 4'd3 || Nin !== 8'h05 || done !== 1'b1)
      $display("FAIL halt_ignore: enter cycles %0d cnt %0d Nin %h done %b, expected 0/3/05/1",
               seen, fifo_count, Nin, done);
    else n_pass++;
    push_byte(8'h77);
    n_total++;
    if (fifo_count !== 4'd4) $display("FAIL halt_push: got cnt %0d expected 4", fifo_count);
    else n_pass++;
  endtask

  task automatic test_reset_mid_pulse();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) push_byte(8'h30 + 8'(i));
    cpu_out_strobe = 1'b1;
    cpu_Nout = 8'h99;
    tick();
    cpu_out_strobe = 1'b0;
    cpu_in_req = 1'b1;
    tick();
    tick();
    n_total++;
    if (enter !== 1'b1 || overflow !== 1'b1 || out_valid !== 1'b1)
      $display("FAIL rst_pre: got enter=%b ovf=%b valid=%b, expected 1/1/1", enter, overflow, out_valid);
    else n_pass++;
    #2;
    reset = 1'b0;
    cpu_in_req = 1'b0;
    #1;
    n_total++;
    if (enter !== 1'b0) $display("FAIL rst_enter: got %b expected 0", enter);
    else n_pass++;
    n_total++;
    if (fifo_count !== 4'd0 || fifo_full !== 1'b0 || overflow !== 1'b0 || starved !== 1'b0)
      $display("FAIL rst_fifo: got cnt=%0d full=%b ovf=%b starved=%b, expected 0/0/0/0",
               fifo_count, fifo_full, overflow, starved);
    else n_pass++;
    n_total++;
    if (Nin !== 8'h00 || out_valid !== 1'b0 || out_count !== 8'd0 || done !== 1'b0)
      $display("FAIL rst_out: got Nin=%h valid=%b count=%0d done=%b, expected 00/0/0/0",
               Nin, out_valid, out_count, done);
    else n_pass++;
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_handshake();
    test_starvation();
    test_overflow();
    test_output_capture();
    test_halt();
    test_reset_mid_pulse();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cpu_io_host.md
# cpu_io_host

Host-side I/O responder for the 8-bit accumulator CPU. It supplies the CPU's `Nin`/`enter` input handshake from a small input FIFO filled by the host, and captures every value the CPU writes to `Nout`. It also latches `halt`. It sits beside the CPU top level on the same fast clock and stretches `enter` so the slow, divided CPU clock always samples it.

## Interface
Parameters:
- `DEPTH`, default 8: input FIFO entries (power of two).
- `ENTER_HOLD`, default 4: fast-clock cycles `enter` is held high; must be ≥ the CPU clock-divide ratio.
- `SETUP`, default 1: cycles `Nin` is stable before `enter` rises.

Ports:
- `clock`, in, 1: system clock; all state changes on its rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `host_data`, in, 8: byte to queue for the CPU.
- `host_push`, in, 1: single-cycle write strobe for `host_data`.
- `fifo_count`, out, $clog2(DEPTH)+1: number of queued bytes.
- `fifo_full`, out, 1: high when `fifo_count == DEPTH`.
- `overflow`, out, 1: sticky; set by a push while full.
- `cpu_in_req`, in, 1: level, CPU is in its input-wait state.
- `Nin`, out, 8: data to the CPU.
- `enter`, out, 1: input strobe to the CPU.
- `starved`, out, 1: `cpu_in_req` is high while the FIFO is empty.
- `cpu_out_strobe`, in, 1: single-cycle pulse (fast-clock domain) when the CPU executes OUT.
- `cpu_Nout`, in, 8: CPU output register.
- `cpu_halt`, in, 1: CPU halt.
- `out_data`, out, 8: captured output byte.
- `out_valid`, out, 1: `out_data` is holding unread data.
- `out_pop`, in, 1: host consumes `out_data`.
- `out_count`, out, 8: total OUT events since reset; saturates at 255.
- `done`, out, 1: sticky, CPU halted.

## Operation
The FSM has five states:
- **IDLE**:
  - If `cpu_in_req` is high and the FIFO is non-empty, pop the head into the `Nin` register and go to SETUP.
  - `starved = cpu_in_req & empty`.
- **SETUP**: hold `Nin` for `SETUP` cycles, then go to PULSE.
- **PULSE**: `enter` is 1 for exactly `ENTER_HOLD` cycles, then go to ACK.
- **ACK**: `enter` is 0. Wait for `cpu_in_req` to go low, then return to IDLE. This prevents a second byte being delivered to the same request.
- **HALTED**:
  - Entered from any state when `cpu_halt` is seen high. This has priority over all other transitions.
  - `enter` is forced to 0. The state is absorbing until reset.
  - Pushes are still accepted.

FIFO rules:
- A push while full is dropped and sets `overflow`.
- A push and an FSM pop in the same cycle are both performed and the count is unchanged. When the FIFO is empty, the push lands and no pop occurs.
- Read and write pointers wrap modulo `DEPTH`.

Output capture:
- On `cpu_out_strobe`, `cpu_Nout` is captured and `out_count` increments (it saturates at 255).
- A strobe and an `out_pop` in the same cycle: the new data wins and `out_valid` stays 1.

## Timing
Reset values:
- `Nin` = 0, `enter` = 0, FSM = IDLE, FIFO empty, `fifo_count` = 0.
- `overflow` = 0, `starved` = 0, `out_data` = 0, `out_valid` = 0, `out_count` = 0, `done` = 0.

Reset behaviour:
- Asserting reset mid-PULSE drops `enter` immediately (asynchronously) and discards queued bytes.

Latency:
- `cpu_in_req` rising edge (FIFO non-empty) → `Nin` valid 1 cycle later → `enter` rises after `SETUP` more cycles → `enter` falls `ENTER_HOLD` cycles later.
- `Nin` holds its value until the next pop.
- `fifo_count`, `fifo_full` and `out_count` are registered and update 1 cycle after the event.
- `cpu_out_strobe` → `out_valid`/`out_data` 1 cycle later.
- `cpu_halt` → `done` 1 cycle later.

Starvation:
- If the FIFO is empty when the request arrives, the first push is delivered. The pop happens the cycle after the push is written.

## Configuration
`CPU_IO_OUTLOG_EN`:
- **Defined**: captured outputs go into a second `DEPTH`-entry FIFO.
  - `out_data` is the head and `out_valid` means non-empty.
  - `out_pop` advances the head.
  - A strobe while the FIFO is full drops the byte and sets the sticky `overflow`.
- **Undefined**: a single holding register is used.
  - A new strobe overwrites unread data.
  - `out_pop` clears `out_valid`.

## Structure
- Package `cpu_io_pkg` holds:
  - the FSM state enum (IDLE, SETUP, PULSE, ACK, HALTED);
  - the data width constant (8);
  - the `out_count` saturation constant.
- Sub-module `cpu_io_fifo` (parameterised depth/width, push/pop, count, full/empty) is used for the input queue. The same sub-module is used for the output log when `CPU_IO_OUTLOG_EN` is defined.

## Test plan
- **Basic handshake.** Push 0x2A, then raise `cpu_in_req`.
  - Required: `Nin` = 0x2A; `enter` high for exactly 4 cycles after 1 setup cycle.
  - With `cpu_in_req` held high 10 more cycles: no second `enter` pulse.
- **Starvation.** Raise `cpu_in_req` with the FIFO empty.
  - Required: `starved` = 1 and `enter` = 0.
  - Then push 0x05: `starved` clears and `Nin` = 0x05 with an `enter` pulse.
- **Full/overflow.** Push 9 bytes 0x01..0x09.
  - Required: `fifo_full` = 1, `overflow` = 1.
  - Four handshakes deliver 0x01..0x04 in order.
- **Output capture.** Pulse `cpu_out_strobe` with `cpu_Nout` = 0x11, then 0x22, with no pop.
  - With the macro undefined: `out_data` = 0x22, `out_count` = 2.
  - With the macro defined: pops return 0x11 then 0x22.
- **Halt mid-pulse.** Assert `cpu_halt` during PULSE.
  - Required: next cycle `enter` = 0, `done` = 1, and later `cpu_in_req` requests are ignored.
- **Reset mid-pulse.** Drive `reset` low mid-PULSE.
  - Required: `enter` = 0 immediately, `fifo_count` = 0, all flags cleared.
